// File: rtl/turbosound_n_pkg.sv
// Shared constants and types for the turbosound_n multi-AY front end.
package turbosound_n_pkg;

  localparam int AY_CHAN_W     = 8;
  localparam logic [5:0] AY_SEL_PREFIX = 6'b111111;
  localparam int AY_MAX_CHIPS  = 4;

  // Packed per-chip channel field: {A[23:16], B[15:8], C[7:0]}
  localparam int AY_CHIP_W = 3 * AY_CHAN_W;
  localparam int AY_OFS_A  = 16;
  localparam int AY_OFS_B  = 8;
  localparam int AY_OFS_C  = 0;

  typedef enum logic [1:0] {
    CH_A = 2'd0,
    CH_B = 2'd1,
    CH_C = 2'd2
  } ay_chan_e;

endpackage

// File: rtl/turbosound_mix.sv
// Time-multiplexed channel mixer: one channel per cycle, one sample per 3*NUM_AY cycles.
// Define TURBOSOUND_STEREO_EN for ABC panning; the default build mixes mono.
module turbosound_mix
  import turbosound_n_pkg::*;
#(
  parameter int NUM_AY = 3,
  parameter int OUT_W  = 10 + $clog2(NUM_AY)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_AY-1:0]           chip_en,
  input  logic [AY_CHIP_W*NUM_AY-1:0] ay_chan,
  output logic [OUT_W-1:0]            audio_l,
  output logic [OUT_W-1:0]            audio_r,
  output logic                        audio_valid
);

  localparam int CHIP_W = (NUM_AY > 1) ? $clog2(NUM_AY) : 1;

  // The step counter is kept as {chip, channel} so no divide by 3 is needed.
  logic [CHIP_W-1:0]    chip;
  ay_chan_e             ch;
  logic [AY_CHAN_W-1:0] lvl;
  logic [OUT_W-1:0]     term_l, term_r, acc_l, acc_r;
  logic                 first, last;

  assign first = (chip == '0) && (ch == CH_A);
  assign last  = (chip == CHIP_W'(NUM_AY - 1)) && (ch == CH_C);

  always_comb begin
    lvl = '0;
    for (int i = 0; i < NUM_AY; i++) begin
      if (chip == CHIP_W'(i) && chip_en[i] && chip_en[0]) begin
        case (ch)
          CH_A:    lvl = ay_chan[i*AY_CHIP_W + AY_OFS_A +: AY_CHAN_W];
          CH_B:    lvl = ay_chan[i*AY_CHIP_W + AY_OFS_B +: AY_CHAN_W];
          CH_C:    lvl = ay_chan[i*AY_CHIP_W + AY_OFS_C +: AY_CHAN_W];
          default: lvl = '0;
        endcase
      end
    end
  end

`ifdef TURBOSOUND_STEREO_EN
  always_comb begin
    term_l = '0;
    term_r = '0;
    case (ch)
      CH_A: term_l = OUT_W'(lvl) << 1;
      CH_B: begin
        term_l = OUT_W'(lvl);
        term_r = OUT_W'(lvl);
      end
      CH_C: term_r = OUT_W'(lvl) << 1;
      default: ;
    endcase
  end
`else
  assign term_l = OUT_W'(lvl);
  assign term_r = OUT_W'(lvl);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chip        <= '0;
      ch          <= CH_A;
      acc_l       <= '0;
      acc_r       <= '0;
      audio_l     <= '0;
      audio_r     <= '0;
      audio_valid <= 1'b0;
    end else begin
      // Step 0 loads rather than accumulates, so no separate clear cycle is needed.
      acc_l       <= first ? term_l : acc_l + term_l;
      acc_r       <= first ? term_r : acc_r + term_r;
      audio_valid <= last;
      if (last) begin
        audio_l <= acc_l + term_l;
        audio_r <= acc_r + term_r;
        chip    <= '0;
        ch      <= CH_A;
      end else if (ch == CH_C) begin
        chip <= chip + CHIP_W'(1);
        ch   <= CH_A;
      end else begin
        ch <= (ch == CH_A) ? CH_B : CH_C;
      end
    end
  end

endmodule

// File: rtl/turbosound_n.sv
// Multi-AY front end: chip select tracking, read-back mux and shared audio mixer.
// Optional ABC stereo panning via TURBOSOUND_STEREO_EN (mono when undefined).
module turbosound_n
  import turbosound_n_pkg::*;
#(
  parameter int NUM_AY = 3,
  parameter int OUT_W  = 10 + $clog2(NUM_AY)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_AY-1:0]           chip_en,
  input  logic                        bdir,
  input  logic                        bc1,
  input  logic [7:0]                  din,
  input  logic [8*NUM_AY-1:0]         ay_dout,
  input  logic [NUM_AY-1:0]           ay_oe_n,
  input  logic [AY_CHIP_W*NUM_AY-1:0] ay_chan,
  output logic [NUM_AY-1:0]           ay_a8,
  output logic [7:0]                  dout,
  output logic                        oe_n,
  output logic [OUT_W-1:0]            audio_l,
  output logic [OUT_W-1:0]            audio_r,
  output logic                        audio_valid
);

  localparam int SEL_W = (NUM_AY > 1) ? $clog2(NUM_AY) : 1;

  logic [SEL_W-1:0]        sel;
  logic [1:0]              wr_idx;
  logic [AY_MAX_CHIPS-1:0] en_ext;
  logic                    sel_wr, sel_ok, sel_en, sel_oe_n;

  // 0xFF selects chip 0, counting down to 0xFC for chip 3.
  assign wr_idx = 2'd3 - din[1:0];
  assign en_ext = AY_MAX_CHIPS'(chip_en);
  assign sel_wr = bdir && bc1 && (din[7:2] == AY_SEL_PREFIX);
  assign sel_ok = sel_wr && (int'(wr_idx) < NUM_AY) && en_ext[wr_idx] && chip_en[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    sel <= '0;
    else if (sel_ok) sel <= SEL_W'(wr_idx);
  end

  always_comb begin
    sel_en   = 1'b0;
    sel_oe_n = 1'b1;
    dout     = ay_dout[7:0];
    ay_a8    = '0;
    for (int i = 0; i < NUM_AY; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_en   = chip_en[i];
        sel_oe_n = ay_oe_n[i];
        dout     = ay_dout[i*8 +: 8];
        ay_a8[i] = chip_en[i] && chip_en[0];
      end
    end
  end

  assign oe_n = ~(sel_en & chip_en[0] & ~sel_oe_n);

  turbosound_mix #(
    .NUM_AY (NUM_AY),
    .OUT_W  (OUT_W)
  ) u_mix (
    .clk         (clk),
    .reset_n     (reset_n),
    .chip_en     (chip_en),
    .ay_chan     (ay_chan),
    .audio_l     (audio_l),
    .audio_r     (audio_r),
    .audio_valid (audio_valid)
  );

endmodule

// File: tb/tb_turbosound_n.sv
// Self-checking bench for turbosound_n with NUM_AY=3; audio samples go through a scoreboard queue.
module tb_turbosound_n;

  localparam int NUM_AY = 3;
  localparam int OUT_W  = 12;
  localparam int PERIOD = 3 * NUM_AY;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NUM_AY-1:0]    chip_en;
  logic                 bdir, bc1;
  logic [7:0]           din;
  logic [8*NUM_AY-1:0]  ay_dout;
  logic [NUM_AY-1:0]    ay_oe_n;
  logic [24*NUM_AY-1:0] ay_chan;
  logic [NUM_AY-1:0]    ay_a8;
  logic [7:0]           dout;
  logic                 oe_n;
  logic [OUT_W-1:0]     audio_l, audio_r;
  logic                 audio_valid;

  typedef struct { int l; int r; } smp_t;
  smp_t q[$];
  smp_t mon_s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  turbosound_n #(.NUM_AY(NUM_AY), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset_n(reset_n), .chip_en(chip_en), .bdir(bdir), .bc1(bc1),
    .din(din), .ay_dout(ay_dout), .ay_oe_n(ay_oe_n), .ay_chan(ay_chan),
    .ay_a8(ay_a8), .dout(dout), .oe_n(oe_n), .audio_l(audio_l),
    .audio_r(audio_r), .audio_valid(audio_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Reference mix of one full sweep with levels held constant.
  task automatic model(input logic [24*NUM_AY-1:0] chan, input logic [NUM_AY-1:0] en,
                       output int l, output int r);
    int a, b, c;
    l = 0;
    r = 0;
    for (int i = 0; i < NUM_AY; i++) begin
      if (en[i] && en[0]) begin
        a = int'(chan[i*24+16 +: 8]);
        b = int'(chan[i*24+8 +: 8]);
        c = int'(chan[i*24 +: 8]);
`ifdef TURBOSOUND_STEREO_EN
        l += 2*a + b;
        r += 2*c + b;
`else
        l += a + b + c;
        r += a + b + c;
`endif
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (audio_valid && q.size() > 0) begin
      mon_s = q.pop_front();
      check("audio_l", 32'(audio_l), 32'(mon_s.l));
      check("audio_r", 32'(audio_r), 32'(mon_s.r));
    end
  end

  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!audio_valid && cyc < 4*PERIOD);
    if (!audio_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic sel_write(input logic [7:0] v);
    @(negedge clk);
    bdir = 1'b1; bc1 = 1'b1; din = v;
    @(posedge clk);
    #1;
    @(negedge clk);
    bdir = 1'b0; bc1 = 1'b0; din = 8'h00;
  endtask

  // Called at the negedge right after a valid pulse; the next sweep mixes these levels.
  task automatic play(input string tag, input logic [24*NUM_AY-1:0] chan, input logic [NUM_AY-1:0] en);
    smp_t s;
    int cyc;
    ay_chan = chan;
    chip_en = en;
    model(chan, en, s.l, s.r);
    q.push_back(s);
    wait_valid(tag, cyc);
    check({tag, "_period"}, 32'(cyc), 32'(PERIOD));
  endtask

  initial begin
    int cyc;
    logic [24*NUM_AY-1:0] rnd;
    smp_t s;
    reset_n = 1'b0;
    chip_en = 3'b111;
    bdir = 1'b0; bc1 = 1'b0; din = 8'h00;
    ay_dout = {8'hC2, 8'hB1, 8'hA0};
    ay_oe_n = 3'b111;
    ay_chan = '0;
    #23;
    check("rst_ay_a8", 32'(ay_a8), 32'b001);
    check("rst_dout", 32'(dout), 32'hA0);
    check("rst_oe_n", 32'(oe_n), 1);
    check("rst_audio_l", 32'(audio_l), 0);
    check("rst_audio_r", 32'(audio_r), 0);
    check("rst_valid", 32'(audio_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;

    ay_oe_n = 3'b110; #1;
    check("oe_chip0", 32'(oe_n), 0);
    ay_oe_n = 3'b111;

    sel_write(8'hFE);
    check("sel_fe_a8", 32'(ay_a8), 32'b010);
    check("sel_fe_dout", 32'(dout), 32'hB1);
    sel_write(8'hFD);
    check("sel_fd_a8", 32'(ay_a8), 32'b100);
    check("sel_fd_dout", 32'(dout), 32'hC2);
    ay_dout[23:16] = 8'h5A; #1;
    check("dout_track", 32'(dout), 32'h5A);
    sel_write(8'hFC);
    check("sel_fc_ignored", 32'(ay_a8), 32'b100);
    chip_en = 3'b101;
    sel_write(8'hFE);
    check("sel_dis_ignored", 32'(ay_a8), 32'b100);
    chip_en = 3'b111;
    sel_write(8'h07);
    check("addr_wr_ignored", 32'(ay_a8), 32'b100);

    ay_oe_n = 3'b011; #1;
    check("oe_sel2", 32'(oe_n), 0);
    chip_en = 3'b011; #1;
    check("dis_sel_oe_n", 32'(oe_n), 1);
    check("dis_sel_a8", 32'(ay_a8), 0);
    chip_en = 3'b111; #1;
    check("reen_sel_a8", 32'(ay_a8), 32'b100);

    chip_en = 3'b110; #1;
    check("en0_off_a8", 32'(ay_a8), 0);
    check("en0_off_oe_n", 32'(oe_n), 1);
    sel_write(8'hFF);
    chip_en = 3'b111; #1;
    check("en0_off_wr_ignored", 32'(ay_a8), 32'b100);
    sel_write(8'hFE);
    check("sel_fe_again", 32'(ay_a8), 32'b010);

    // Audio sweeps: align to a sample boundary, then feed one level set per sweep.
    wait_valid("align", cyc);
    play("a0_only", {24'h000000, 24'h000000, 24'hFF0000}, 3'b111);
    play("all_b100", {24'h006400, 24'h006400, 24'h006400}, 3'b111);
    play("all_255", {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF}, 3'b111);
    play("en0_off", {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF}, 3'b110);
    play("c_only", {24'h000080, 24'h000040, 24'h000011}, 3'b111);
    for (int k = 0; k < 3; k++) begin
      rnd = {24'($urandom), 24'($urandom), 24'($urandom)};
      play("rand", rnd, 3'($urandom_range(1, 7)) | 3'b001);
    end
    rnd = {24'($urandom), 24'($urandom), 24'($urandom)};
    play("rand_en101", rnd, 3'b101);
    play("pre_reset", {24'h102030, 24'h405060, 24'h708090}, 3'b111);

    // Reset in the middle of a sweep, with sel=1 and a nonzero last sample.
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0; #1;
    check("mid_rst_audio_l", 32'(audio_l), 0);
    check("mid_rst_audio_r", 32'(audio_r), 0);
    check("mid_rst_valid", 32'(audio_valid), 0);
    check("mid_rst_sel", 32'(ay_a8), 32'b001);
    model(ay_chan, chip_en, s.l, s.r);
    q.push_back(s);
    @(negedge clk);
    reset_n = 1'b1;
    wait_valid("post_reset", cyc);
    check("post_reset_latency", 32'(cyc), 32'(PERIOD));
    @(negedge clk);
    check("queue_drained", 32'(q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
